// File: rtl/apb_master_bridge.sv
// ============================================================================
// apb_master_bridge : host req/ack register bus to APB3 master, with timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_master_bridge #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wd,
  output logic          req_ack,
  output logic [31:0]   req_rd,
  output logic          req_err,
  output logic          busy,
  output logic [AW-1:0] paddr,
  output logic [31:0]   pwdata,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  input  logic [31:0]   prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  // Abort fires at the end of the TIMEOUT-th consecutive not-ready ACCESS cycle.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // psel is registered and high exactly in SETUP and ACCESS.
  assign busy = psel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      req_ack  <= 1'b0;
      req_rd   <= '0;
      req_err  <= 1'b0;
    end else begin
      req_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !req_ack) begin
            state    <= SETUP;
            paddr    <= req_addr;
            pwrite   <= req_we;
            pwdata   <= req_wd;
            psel     <= 1'b1;
            penable  <= 1'b0;
            wait_cnt <= '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            req_ack <= 1'b1;
            req_err <= pslverr;
            req_rd  <= pwrite ? 32'd0 : prdata;
          end else if (timeout_hit) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            req_ack <= 1'b1;
            req_err <= 1'b1;
            req_rd  <= 32'd0;
          end else if (TIMEOUT > 0) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
